// File: rtl/cgb_reset_seq.sv
// Reset sequencer around the MMCM: pulses MMCM RST, waits for a debounced lock,
// retries on timeout and releases the downstream domain resets in order.
module cgb_reset_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 1_000_000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 4,
  parameter int NSTAGE           = 3,
  parameter int STAGE_GAP_CYC    = 64,
  localparam int RW              = $clog2(MAX_RETRY + 1)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOCK,
  input  logic              iREQ,
  output logic              oMMCM_RST,
  output logic [NSTAGE-1:0] oRST,
  output logic              oREADY,
  output logic              oFAIL,
  output logic [RW-1:0]     oRETRY_CNT
);

  localparam int REL_LAST = (NSTAGE - 1) * STAGE_GAP_CYC;
  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int GW = $clog2(REL_LAST + 2);

  typedef enum logic [2:0] {
    ST_ASSERT, ST_WAIT_LOCK, ST_STABLE, ST_RELEASE, ST_RUN, ST_FAIL
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [GW-1:0] rel_q, rel_d;
  logic [RW-1:0] retry_q, retry_d;
  logic lk_meta_q, lk_meta_d, lk_s_q, lk_s_d;
  logic mmcm_rst_q, mmcm_rst_d, ready_q, ready_d, fail_q, fail_d;
  logic [NSTAGE-1:0] rst_q, rst_d;

  always_comb begin
    lk_meta_d = iLOCK;
    lk_s_d    = lk_meta_q;
    state_d   = state_q;
    pulse_d   = pulse_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    rel_d     = rel_q;
    retry_d   = retry_q;

    // iREQ outranks every in-state decision; iRST is handled in the flop block
    if (iREQ) begin
      state_d = ST_ASSERT;
      pulse_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (pulse_q >= PW'(RST_PULSE_CYC - 1)) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (timer_q >= TW'(LOCK_TIMEOUT_CYC - 1)) begin
            retry_d = retry_q + 1'b1;
            pulse_d = '0;
            state_d = (retry_q >= RW'(MAX_RETRY - 1)) ? ST_FAIL : ST_ASSERT;
          end else if (lk_s_q) begin
            if (LOCK_STABLE_CYC <= 1) begin
              state_d = ST_RELEASE;
              rel_d   = '0;
            end else begin
              state_d  = ST_STABLE;
              stable_d = SW'(1);
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lk_s_q) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (stable_q >= SW'(LOCK_STABLE_CYC - 1)) begin
            state_d = ST_RELEASE;
            rel_d   = '0;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!lk_s_q) begin
            state_d = ST_ASSERT;
            pulse_d = '0;
          end else if (rel_q >= GW'(REL_LAST)) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk_s_q) begin
            state_d = ST_ASSERT;
            pulse_d = '0;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: begin
          state_d = ST_ASSERT;
          pulse_d = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with it
    mmcm_rst_d = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
    ready_d    = (state_d == ST_RUN);
    fail_d     = (state_d == ST_FAIL);
    rst_d      = '1;
    if (state_d == ST_RUN) begin
      rst_d = '0;
    end else if (state_d == ST_RELEASE) begin
      for (int k = 0; k < NSTAGE; k++) begin
        rst_d[k] = (int'(rel_d) < k * STAGE_GAP_CYC);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q    <= ST_ASSERT;
      pulse_q    <= '0;
      timer_q    <= '0;
      stable_q   <= '0;
      rel_q      <= '0;
      retry_q    <= '0;
      lk_meta_q  <= 1'b0;
      lk_s_q     <= 1'b0;
      mmcm_rst_q <= 1'b1;
      rst_q      <= '1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pulse_q    <= pulse_d;
      timer_q    <= timer_d;
      stable_q   <= stable_d;
      rel_q      <= rel_d;
      retry_q    <= retry_d;
      lk_meta_q  <= lk_meta_d;
      lk_s_q     <= lk_s_d;
      mmcm_rst_q <= mmcm_rst_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  assign oMMCM_RST  = mmcm_rst_q;
  assign oRST       = rst_q;
  assign oREADY     = ready_q;
  assign oFAIL      = fail_q;
  assign oRETRY_CNT = retry_q;

endmodule

// File: tb/tb_cgb_reset_seq.sv
// Scoreboard bench for cgb_reset_seq: a phase/timestamp reference model predicts every
// output change; a negedge monitor compares each observed change against it.
module tb_cgb_reset_seq;

  localparam int P  = 4;
  localparam int T  = 50;
  localparam int S  = 8;
  localparam int MR = 2;
  localparam int N  = 3;
  localparam int G  = 5;

  logic iCLK, iRST, iLOCK, iREQ;
  logic oMMCM_RST, oREADY, oFAIL;
  logic [N-1:0] oRST;
  logic [1:0] oRETRY_CNT;

  cgb_reset_seq #(
    .RST_PULSE_CYC(P), .LOCK_TIMEOUT_CYC(T), .LOCK_STABLE_CYC(S),
    .MAX_RETRY(MR), .NSTAGE(N), .STAGE_GAP_CYC(G)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iLOCK(iLOCK), .iREQ(iREQ),
    .oMMCM_RST(oMMCM_RST), .oRST(oRST), .oREADY(oREADY), .oFAIL(oFAIL),
    .oRETRY_CNT(oRETRY_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int cyc;
    logic [7:0] val;
  } ev_t;

  typedef enum int {PH_PULSE, PH_WAIT, PH_STABLE, PH_REL, PH_RUN, PH_DEAD} phase_t;

  ev_t sb[$];
  int checks = 0;
  int failures = 0;
  int stim_cyc = 0;

  task automatic applyStimulus(input logic rst_n, input logic lock, input logic req, input int n);
    iRST  = rst_n;
    iLOCK = lock;
    iREQ  = req;
    repeat (n) @(posedge iCLK);
    #1;
    stim_cyc += n;
  endtask

  task automatic checkOutput(input int cyc, input logic [7:0] val);
    ev_t ev;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL out_change cycle=%0d actual=%b required=no change", cyc, val);
    end else begin
      ev = sb.pop_front();
      if (ev.cyc != cyc || ev.val !== val) begin
        failures++;
        $display("[TB] FAIL out_event actual=%b@%0d required=%b@%0d", val, cyc, ev.val, ev.cyc);
      end
    end
  endtask

  // Reference model: each phase remembers the cycle it was entered and decides from elapsed time
  initial begin : model
    phase_t phase;
    int start, retries, mcyc, el;
    bit lk_hist[$];
    bit lks;
    logic [7:0] exp_prev;
    logic [7:0] exp_now;
    logic [N-1:0] rv;
    ev_t ev;
    phase = PH_PULSE;
    start = 0;
    retries = 0;
    mcyc = 0;
    lk_hist = '{1'b0, 1'b0};
    exp_prev = 'x;
    forever begin
      @(posedge iCLK);
      mcyc++;
      lks = lk_hist[0];
      if (!iRST) begin
        phase = PH_PULSE;
        start = mcyc;
        retries = 0;
        lk_hist = '{1'b0, 1'b0};
      end else begin
        el = mcyc - start;
        void'(lk_hist.pop_front());
        lk_hist.push_back(iLOCK);
        if (iREQ) begin
          phase = PH_PULSE; start = mcyc; retries = 0;
        end else begin
          case (phase)
            PH_PULSE: if (el == P) begin phase = PH_WAIT; start = mcyc; end
            PH_WAIT: begin
              if (el == T) begin
                retries++;
                phase = (retries == MR) ? PH_DEAD : PH_PULSE;
                start = mcyc;
              end else if (lks) begin
                phase = (S == 1) ? PH_REL : PH_STABLE;
                start = mcyc;
              end
            end
            PH_STABLE: begin
              if (!lks) begin phase = PH_WAIT; start = mcyc; end
              else if (el == S - 1) begin phase = PH_REL; start = mcyc; end
            end
            PH_REL: begin
              if (!lks) begin phase = PH_PULSE; start = mcyc; end
              else if (el == (N - 1) * G + 1) begin phase = PH_RUN; start = mcyc; retries = 0; end
            end
            PH_RUN: if (!lks) begin phase = PH_PULSE; start = mcyc; end
            default: ;
          endcase
        end
      end
      el = mcyc - start;
      rv = '1;
      if (phase == PH_RUN) rv = '0;
      else if (phase == PH_REL)
        for (int k = 0; k < N; k++) rv[k] = !(el >= k * G);
      exp_now = {(phase == PH_PULSE || phase == PH_DEAD), rv, (phase == PH_RUN),
                 (phase == PH_DEAD), 2'(retries)};
      if (exp_now !== exp_prev) begin
        ev.cyc = mcyc;
        ev.val = exp_now;
        sb.push_back(ev);
        exp_prev = exp_now;
      end
    end
  end

  initial begin : monitor
    int ncyc;
    logic [7:0] cur, prev;
    ncyc = 0;
    prev = 'x;
    forever begin
      @(negedge iCLK);
      ncyc++;
      cur = {oMMCM_RST, oRST, oREADY, oFAIL, oRETRY_CNT};
      if (cur !== prev) begin
        checkOutput(ncyc, cur);
        checks++;
        for (int k = 1; k < N; k++) begin
          if (!oRST[k] && oRST[k-1]) begin
            failures++;
            $display("[TB] FAIL rst_order cycle=%0d actual=%b required=lower bits released first", ncyc, oRST);
            break;
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : driver
    int mode, len;
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    // Lock arrives 10 cycles after the MMCM reset pulse, then a full release
    applyStimulus(1'b1, 1'b0, 1'b0, P + 10);
    applyStimulus(1'b1, 1'b1, 1'b0, 120);
    // One-cycle lock drop while running, then re-release
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 120);
    // Lock never comes back: two timeouts then FAIL, then re-init request
    applyStimulus(1'b1, 1'b0, 1'b0, 300);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, P + 2);
    // Glitch while counting stable cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16);
    // Synchronous reset mid-release, then request together with lock loss in RUN
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 60);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 80);
    while (stim_cyc < 10000) begin
      mode = $urandom_range(0, 99);
      if (mode < 40) begin
        applyStimulus(1'b1, 1'b1, 1'b0, $urandom_range(20, 200));
      end else if (mode < 60) begin
        applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(1, 4));
      end else if (mode < 75) begin
        applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(40, 250));
      end else if (mode < 85) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1);
      end else if (mode < 92) begin
        len = $urandom_range(10, 40);
        for (int i = 0; i < len; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1);
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 3));
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 60);
    repeat (3) @(negedge iCLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_events actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
